// File: rtl/tty_pkg.sv
// Shared types and constants for the serial transmitter.
// Build option: define TTY_XMIT_PARITY_EN to send even parity in bit 7.
package tty_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tty_state_e;

  localparam logic TX_IDLE = 1'b1;

  // Even parity over the seven data bits.
  function automatic logic even_par(input logic [6:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tty_baud.sv
// Bit-time generator: one-cycle tick every CLKDIV enabled cycles.
// Restarted from zero by start_i so each frame is phase aligned.
module tty_baud #(
  parameter int CLKDIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: restart on load, wrap on tick, park at zero when idle.
  always_comb begin
    cnt_d = '0;
    if (start_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Bit-time counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tty_xmit.sv
// Async serial transmitter: start bit, 8 data bits LSB first, stop bits.
// Build option: define TTY_XMIT_PARITY_EN to send even parity in bit 7.
module tty_xmit
  import tty_pkg::*;
#(
  parameter int CLKDIV   = 4,
  parameter int STOPBITS = 2
) (
  input  logic       T,
  input  logic       _PC,
  input  logic       ld,
  input  logic [7:0] ldata,
  input  logic       clrflag,
  output logic       busy,
  output logic       flag,
  output logic       tx
);

  localparam logic [3:0] SLAST = 4'(STOPBITS - 1);

  tty_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       flag_q, flag_d;
  logic       tick;
  logic       ld_acc;
  logic       frame_done;
  logic [7:0] ld_word;

  assign ld_acc = ld && (state_q == IDLE);
  assign busy   = (state_q != IDLE);
  assign flag   = flag_q;

`ifdef TTY_XMIT_PARITY_EN
  assign ld_word = {even_par(ldata[6:0]), ldata[6:0]};
`else
  assign ld_word = ldata;
`endif

  tty_baud #(
    .CLKDIV (CLKDIV)
  ) u_baud (
    .clk_i   (T),
    .rst_ni  (_PC),
    .start_i (ld_acc),
    .en_i    (busy),
    .tick_o  (tick)
  );

  // Frame sequencing: next state, shift register and bit counter.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld) begin
          state_d  = START;
          shreg_d  = ld_word;
          bitcnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 4'd7) begin
            state_d  = STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bitcnt_q == SLAST) begin
            state_d    = IDLE;
            bitcnt_d   = '0;
            frame_done = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  // Done flag: cleared by clrflag or a new load, set wins on frame end.
  always_comb begin
    flag_d = flag_q;
    if (clrflag || ld_acc) begin
      flag_d = 1'b0;
    end
    if (frame_done) begin
      flag_d = 1'b1;
    end
  end

  // Line level decoded from state so reset idles the line at once.
  always_comb begin
    tx = TX_IDLE;
    unique case (state_q)
      IDLE:    tx = TX_IDLE;
      START:   tx = ~TX_IDLE;
      DATA:    tx = shreg_q[0];
      STOP:    tx = TX_IDLE;
      default: tx = TX_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge T or negedge _PC) begin
    if (!_PC) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      flag_q   <= flag_d;
    end
  end

endmodule
